// File: rtl/dcache_assoc.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU
// and saturating hit/miss counters; stalls the CPU while a block moves to/from memory.
module dcache_assoc #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned SETS        = 4,
   parameter int unsigned BLOCK_BYTES = 4
) (
   input  logic                                    CLK,
   input  logic                                    RESET,
   input  logic                                    READ,
   input  logic                                    WRITE,
   input  logic [ADDR_W-1:0]                       ADDRESS,
   input  logic [7:0]                              WRITEDATA,
   output logic [7:0]                              READDATA,
   output logic                                    BUSYWAIT,
   output logic                                    MEM_READ,
   output logic                                    MEM_WRITE,
   output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]   MEM_ADDRESS,
   output logic [8*BLOCK_BYTES-1:0]                MEM_WRITEDATA,
   input  logic [8*BLOCK_BYTES-1:0]                MEM_READDATA,
   input  logic                                    MEM_BUSYWAIT,
   output logic [15:0]                             HIT_COUNT,
   output logic [15:0]                             MISS_COUNT
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned BLK_W = 8 * BLOCK_BYTES;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, REFILL} state_t;

   state_t state_q, state_d;

   logic [1:0][SETS-1:0] valid_q;
   logic [1:0][SETS-1:0] dirty_q;
   logic [SETS-1:0]      lru_q;
   logic [TAG_W-1:0]     tag_q  [2][SETS];
   logic [BLK_W-1:0]     data_q [2][SETS];

   logic                 victim_q;
   logic [TAG_W-1:0]     lat_tag_q;
   logic [IDX_W-1:0]     lat_idx_q;
   logic                 refilled_q;
   logic [15:0]          hit_cnt_q;
   logic [15:0]          miss_cnt_q;

   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [OFF_W-1:0]     req_off;
   logic                 req_c;
   logic                 way0_hit_c;
   logic                 way1_hit_c;
   logic                 hit_c;
   logic                 miss_c;
   logic                 hit_way_c;
   logic                 victim_c;
   logic                 fetch_done_c;

   assign req_tag = ADDRESS[ADDR_W-1 -: TAG_W];
   assign req_idx = ADDRESS[OFF_W +: IDX_W];
   assign req_off = ADDRESS[OFF_W-1:0];

   // Tag lookup on the live address; only IDLE serves hits
   assign req_c      = READ | WRITE;
   assign way0_hit_c = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
   assign way1_hit_c = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
   assign hit_c      = req_c && (state_q == IDLE) && (way0_hit_c || way1_hit_c);
   assign miss_c     = req_c && (state_q == IDLE) && !(way0_hit_c || way1_hit_c);
   assign hit_way_c  = way1_hit_c;

   // Fill an empty way first (way0 before way1), otherwise evict the LRU way
   assign victim_c = !valid_q[0][req_idx] ? 1'b0 :
                     !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

   assign fetch_done_c  = (state_q == FETCH) && !MEM_BUSYWAIT;
   assign READDATA      = hit_c ? data_q[hit_way_c][req_idx][{req_off, 3'b000} +: 8] : 8'h00;
   assign MEM_WRITEDATA = data_q[victim_q][lat_idx_q];
   assign HIT_COUNT     = hit_cnt_q;
   assign MISS_COUNT    = miss_cnt_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      MEM_WRITE   = 1'b0;
      MEM_ADDRESS = {lat_tag_q, lat_idx_q};
      case (state_q)
         IDLE: begin
            if (miss_c) begin
               BUSYWAIT = 1'b1;
               state_d  = (valid_q[victim_c][req_idx] && dirty_q[victim_c][req_idx])
                          ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            BUSYWAIT    = 1'b1;
            MEM_WRITE   = 1'b1;
            MEM_ADDRESS = {tag_q[victim_q][lat_idx_q], lat_idx_q};
            if (!MEM_BUSYWAIT) state_d = FETCH;
         end
         FETCH: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) state_d = REFILL;
         end
         REFILL: begin
            BUSYWAIT = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Line metadata, miss bookkeeping and statistics
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q    <= '0;
         dirty_q    <= '0;
         lru_q      <= '0;
         victim_q   <= 1'b0;
         lat_tag_q  <= '0;
         lat_idx_q  <= '0;
         refilled_q <= 1'b0;
         hit_cnt_q  <= 16'h0000;
         miss_cnt_q <= 16'h0000;
      end else begin
         refilled_q <= (state_q == REFILL);
         if (hit_c) begin
            lru_q[req_idx] <= ~hit_way_c;
            if (WRITE) dirty_q[hit_way_c][req_idx] <= 1'b1;
            if (!refilled_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
         end
         if (miss_c) begin
            victim_q  <= victim_c;
            lat_tag_q <= req_tag;
            lat_idx_q <= req_idx;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
         end
         if (state_q == REFILL) begin
            valid_q[victim_q][lat_idx_q] <= 1'b1;
            dirty_q[victim_q][lat_idx_q] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them
   always_ff @(posedge CLK) begin
      if (hit_c && WRITE) data_q[hit_way_c][req_idx][{req_off, 3'b000} +: 8] <= WRITEDATA;
      if (fetch_done_c)   data_q[victim_q][lat_idx_q] <= MEM_READDATA;
      if (state_q == REFILL) tag_q[victim_q][lat_idx_q] <= lat_tag_q;
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: access table with expected stalls/data, plus
// hand-written reset-mid-fetch and counter saturation sequences; memory has L=3.
module tb_dcache_assoc;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;
   logic [15:0] HIT_COUNT;
   logic [15:0] MISS_COUNT;

   int checks   = 0;
   int failures = 0;

   dcache_assoc dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
   );

   always #5 CLK = ~CLK;

   // Block memory: byte a holds a ^ 8'hA5; busy 3 cycles, completes on the 4th edge
   logic [31:0] mem [64];
   int          mem_cnt;
   int          wr_count = 0;
   int          rd_count = 0;
   logic [5:0]  wr_addr  = '0;
   logic [31:0] wr_data  = '0;
   logic [5:0]  rd_log [8];

   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < 3);
   assign MEM_READDATA = mem[MEM_ADDRESS];

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem_cnt <= 0;
         for (int b = 0; b < 64; b++)
            for (int k = 0; k < 4; k++)
               mem[b][8*k +: 8] <= 8'(b*4 + k) ^ 8'hA5;
      end else if (MEM_READ || MEM_WRITE) begin
         if (mem_cnt == 3) begin
            mem_cnt <= 0;
            if (MEM_WRITE) begin
               mem[MEM_ADDRESS] <= MEM_WRITEDATA;
               wr_addr  <= MEM_ADDRESS;
               wr_data  <= MEM_WRITEDATA;
               wr_count <= wr_count + 1;
            end else begin
               if (rd_count < 8) rd_log[rd_count] <= MEM_ADDRESS;
               rd_count <= rd_count + 1;
            end
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
      end
   end

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       chk_rd;
      logic [7:0] exp_rd;
      int         exp_stall;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One CPU access held until BUSYWAIT drops; returns stall cycles and read byte
   task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, output int stall, output logic [7:0] rdata);
      @(negedge CLK);
      READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
      stall = 0;
      #1;
      while (BUSYWAIT === 1'b1 && stall < 40) begin
         stall++;
         @(negedge CLK);
         #1;
      end
      if (stall >= 40) begin
         checks++;
         failures++;
         $display("FAIL access_timeout addr=%h busywait still high after %0d cycles", addr, stall);
      end
      rdata = READDATA;
      @(posedge CLK);
      #1;
      READ = 1'b0; WRITE = 1'b0;
   endtask

   int         st;
   logic [7:0] rb;

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hA1, 6};
      vecs[1]  = '{1'b0, 1'b1, 8'h05, 8'h55, 1'b0, 8'h00, 0};
      vecs[2]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h55, 0};
      vecs[3]  = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 8'h81, 6};
      vecs[4]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hA1, 0};
      vecs[5]  = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 8'h81, 0};
      vecs[6]  = '{1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 8'hE1, 10};
      vecs[7]  = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 8'h81, 0};
      vecs[8]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hA1, 6};
      vecs[9]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h55, 0};
      vecs[10] = '{1'b1, 1'b1, 8'h06, 8'h3C, 1'b0, 8'h00, 0};
      vecs[11] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h3C, 0};

      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      #2 RESET = 1'b0;
      #1;
      chk("rst_busywait", 32'(BUSYWAIT), 32'h0);
      chk("rst_mem_read", 32'(MEM_READ), 32'h0);
      chk("rst_mem_write", 32'(MEM_WRITE), 32'h0);
      chk("rst_readdata", 32'(READDATA), 32'h0);
      chk("rst_hit_count", 32'(HIT_COUNT), 32'h0);
      chk("rst_miss_count", 32'(MISS_COUNT), 32'h0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < 12; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rb);
         chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_readdata", i), 32'(rb), 32'(vecs[i].exp_rd));
         if (i == 2) begin
            chk("hits_after_write_read", 32'(HIT_COUNT), 32'd2);
            chk("misses_after_write_read", 32'(MISS_COUNT), 32'd1);
         end
      end
      chk("table_hit_count", 32'(HIT_COUNT), 32'd8);
      chk("table_miss_count", 32'(MISS_COUNT), 32'd4);
      chk("writeback_count", 32'(wr_count), 32'd1);
      chk("writeback_addr", 32'(wr_addr), 32'h01);
      chk("writeback_block", wr_data, 32'hA2A355A1);
      chk("fetch_count", 32'(rd_count), 32'd4);
      chk("fetch0_addr", 32'(rd_log[0]), 32'h01);
      chk("fetch1_addr", 32'(rd_log[1]), 32'h09);
      chk("fetch2_addr", 32'(rd_log[2]), 32'h11);
      chk("fetch3_addr", 32'(rd_log[3]), 32'h01);
      chk("mem_byte_05", 32'(mem[1][15:8]), 32'h55);

      // No request: no stall, no counting
      @(negedge CLK);
      ADDRESS = 8'h44;
      #1;
      chk("idle_busywait", 32'(BUSYWAIT), 32'h0);
      repeat (3) @(posedge CLK);
      #1;
      chk("idle_hit_count", 32'(HIT_COUNT), 32'd8);
      chk("idle_miss_count", 32'(MISS_COUNT), 32'd4);

      // Reset while FETCH is waiting on memory
      @(negedge CLK);
      READ = 1'b1; ADDRESS = 8'h08;
      repeat (2) @(negedge CLK);
      #1;
      chk("midfetch_mem_read", 32'(MEM_READ), 32'h1);
      chk("midfetch_mem_addr", 32'(MEM_ADDRESS), 32'h02);
      #2;
      RESET = 1'b0; READ = 1'b0;
      #1;
      chk("async_rst_mem_read", 32'(MEM_READ), 32'h0);
      chk("async_rst_busywait", 32'(BUSYWAIT), 32'h0);
      chk("async_rst_hit_count", 32'(HIT_COUNT), 32'h0);
      chk("async_rst_miss_count", 32'(MISS_COUNT), 32'h0);
      @(negedge CLK);
      RESET = 1'b1;
      access(1'b1, 1'b0, 8'h04, 8'h00, st, rb);
      chk("post_rst_stall", 32'(st), 32'd6);
      chk("post_rst_readdata", 32'(rb), 32'hA1);
      chk("post_rst_miss_count", 32'(MISS_COUNT), 32'd1);
      chk("post_rst_hit_count", 32'(HIT_COUNT), 32'd0);

      // Held read hit drives HIT_COUNT into saturation
      @(negedge CLK);
      READ = 1'b1; ADDRESS = 8'h04;
      repeat (65534) @(posedge CLK);
      #1;
      chk("hit_count_fffe", 32'(HIT_COUNT), 32'hFFFE);
      repeat (3) @(posedge CLK);
      #1;
      chk("hit_count_saturated", 32'(HIT_COUNT), 32'hFFFF);
      chk("saturate_busywait", 32'(BUSYWAIT), 32'h0);
      chk("saturate_miss_count", 32'(MISS_COUNT), 32'd1);
      READ = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
